// File: rtl/stage_sequencer.sv
// Central stage controller: owns the PC and walks each instruction through
// fetch, decode, execute and an ordered one-per-cycle write-back sequence.
module stage_sequencer #(
  parameter int WORD    = 16,
  parameter int PC_STEP = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  input  logic            halt_req,
  input  logic            reg_wb_en,
  input  logic            mem_wb_en,
  input  logic            flag_update_en,
  input  logic            jump,
  input  logic            rjump,
  input  logic [WORD-1:0] jump_loc,
  input  logic [WORD-1:0] jump_inc,
  output logic            fetch_tr,
  output logic            reg_tr,
  output logic            dne_tr,
  output logic            reg_wb_tr,
  output logic            mem_wb_tr,
  output logic            flag_update_tr,
  output logic [WORD-1:0] pc,
  output logic            busy,
  output logic [WORD-1:0] retired
);

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, EXEC, SAMPLE, WB_REG, WB_MEM, WB_FLAG, PC_UPD, DONE
  } state_t;

  localparam logic [WORD-1:0] STEP = WORD'(PC_STEP);

  state_t                 state, next_state;
  logic [3:0]             pend;        // {reg, mem, flag, pc}
  logic                   jump_l;
  logic [WORD-1:0]        jump_loc_l;
  logic signed [WORD-1:0] jump_inc_l;

  function automatic state_t first_pending(input logic [3:0] m);
    if (m[3])      return WB_REG;
    else if (m[2]) return WB_MEM;
    else if (m[1]) return WB_FLAG;
    else if (m[0]) return PC_UPD;
    else           return DONE;
  endfunction

  function automatic logic [WORD-1:0] abs_target(input logic [WORD-1:0] loc);
    return loc * STEP;
  endfunction

  // DECODE has already advanced pc by one step, so take it back out here.
  function automatic logic [WORD-1:0] rel_target(input logic [WORD-1:0] cur,
                                                 input logic signed [WORD-1:0] inc);
    logic signed [WORD-1:0] step_s;
    logic signed [WORD-1:0] off;
    step_s = $signed(STEP);
    off    = inc * step_s;
    return cur + $unsigned(off) - STEP;
  endfunction

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (run && !halt_req) next_state = FETCH;
      FETCH:   next_state = DECODE;
      DECODE:  next_state = EXEC;
      EXEC:    next_state = SAMPLE;
      SAMPLE:  next_state = first_pending({reg_wb_en, mem_wb_en, flag_update_en, jump | rjump});
      WB_REG:  next_state = first_pending({1'b0, pend[2:0]});
      WB_MEM:  next_state = first_pending({2'b00, pend[1:0]});
      WB_FLAG: next_state = first_pending({3'b000, pend[0]});
      PC_UPD:  next_state = DONE;
      DONE:    next_state = (run && !halt_req) ? FETCH : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Triggers and busy are registered from next_state so each is high exactly
  // while the FSM sits in the matching state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      pc             <= '0;
      retired        <= '0;
      pend           <= '0;
      jump_l         <= 1'b0;
      fetch_tr       <= 1'b0;
      reg_tr         <= 1'b0;
      dne_tr         <= 1'b0;
      reg_wb_tr      <= 1'b0;
      mem_wb_tr      <= 1'b0;
      flag_update_tr <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state          <= next_state;
      fetch_tr       <= (next_state == FETCH);
      reg_tr         <= (next_state == DECODE);
      dne_tr         <= (next_state == EXEC);
      reg_wb_tr      <= (next_state == WB_REG);
      mem_wb_tr      <= (next_state == WB_MEM);
      flag_update_tr <= (next_state == WB_FLAG);
      busy           <= (next_state != IDLE);
      case (state)
        DECODE:  pc <= pc + STEP;
        SAMPLE: begin
          pend   <= {reg_wb_en, mem_wb_en, flag_update_en, jump | rjump};
          jump_l <= jump;
        end
        WB_REG:  pend[3] <= 1'b0;
        WB_MEM:  pend[2] <= 1'b0;
        WB_FLAG: pend[1] <= 1'b0;
        PC_UPD: begin
          pend[0] <= 1'b0;
          pc      <= jump_l ? abs_target(jump_loc_l) : rel_target(pc, jump_inc_l);
        end
        DONE:    retired <= retired + WORD'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == SAMPLE) begin
      jump_loc_l <= jump_loc;
      jump_inc_l <= $signed(jump_inc);
    end
  end

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: a vector table of chained instructions
// plus hand sequences for mid-instruction reset and halt.
module tb_stage_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, run, halt_req;
  logic        reg_wb_en, mem_wb_en, flag_update_en, jump, rjump;
  logic [15:0] jump_loc, jump_inc;
  logic        fetch_tr, reg_tr, dne_tr, reg_wb_tr, mem_wb_tr, flag_update_tr, busy;
  logic [15:0] pc, retired;

  int checks = 0;
  int errors = 0;

  stage_sequencer #(.WORD(16), .PC_STEP(2)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .halt_req(halt_req),
    .reg_wb_en(reg_wb_en), .mem_wb_en(mem_wb_en), .flag_update_en(flag_update_en),
    .jump(jump), .rjump(rjump), .jump_loc(jump_loc), .jump_inc(jump_inc),
    .fetch_tr(fetch_tr), .reg_tr(reg_tr), .dne_tr(dne_tr), .reg_wb_tr(reg_wb_tr),
    .mem_wb_tr(mem_wb_tr), .flag_update_tr(flag_update_tr), .pc(pc), .busy(busy),
    .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw, mw, fu, j, rj;
    logic [15:0] loc, inc;
    int          lat;
    int          npc;
    int          roff, moff, foff;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic set_in(input logic rw, mw, fu, j, rj, input logic [15:0] loc, inc);
    reg_wb_en = rw; mem_wb_en = mw; flag_update_en = fu;
    jump = j; rjump = rj; jump_loc = loc; jump_inc = inc;
  endtask

  task automatic wait_fetch(input string nm);
    bit seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (fetch_tr) begin seen = 1; break; end
    end
    chk({nm, "_fetch_seen"}, int'(seen), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int lat, roff, moff, foff, rgoff, dnoff, nwb, busy_low, nfetch, idle_seen;

    //            rw mw fu j  rj loc     inc       lat npc     roff moff foff
    vecs[0] = '{0, 0, 0, 0, 0, 16'd0,  16'd0,    5, 2,      -1, -1, -1};
    vecs[1] = '{1, 1, 1, 0, 0, 16'd0,  16'd0,    8, 4,       4,  5,  6};
    vecs[2] = '{1, 0, 0, 1, 0, 16'd10, 16'd0,    7, 20,      4, -1, -1};
    vecs[3] = '{0, 0, 0, 0, 1, 16'd0,  16'hFFFD, 6, 14,     -1, -1, -1};
    vecs[4] = '{0, 0, 0, 1, 1, 16'd3,  16'd5,    6, 6,      -1, -1, -1};
    vecs[5] = '{1, 1, 1, 1, 0, 16'd0,  16'd0,    9, 0,       4,  5,  6};
    vecs[6] = '{0, 0, 0, 0, 1, 16'd0,  16'hFFFF, 6, 16'hFFFE,-1, -1, -1};
    vecs[7] = '{0, 1, 0, 0, 0, 16'd0,  16'd0,    6, 0,      -1,  4, -1};
    vecs[8] = '{0, 0, 1, 0, 1, 16'd0,  16'd2,    7, 4,      -1, -1,  4};

    rst_n = 1'b0; run = 1'b0; halt_req = 1'b0;
    set_in(0, 0, 0, 0, 0, 16'd0, 16'd0);
    repeat (3) @(negedge clk);
    chk("rst_triggers", int'({fetch_tr, reg_tr, dne_tr, reg_wb_tr, mem_wb_tr, flag_update_tr}), 0);
    chk("rst_pc", int'(pc), 0);
    chk("rst_retired", int'(retired), 0);
    chk("rst_busy", int'(busy), 0);

    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_no_run_fetch", int'(fetch_tr), 0);
    chk("idle_no_run_busy", int'(busy), 0);

    run = 1'b1;
    wait_fetch("first");
    chk("first_fetch_pc", int'(pc), 0);

    for (int v = 0; v < 9; v++) begin
      set_in(vecs[v].rw, vecs[v].mw, vecs[v].fu, vecs[v].j, vecs[v].rj, vecs[v].loc, vecs[v].inc);
      lat = -1; roff = -1; moff = -1; foff = -1; rgoff = -1; dnoff = -1; nwb = 0; busy_low = 0;
      for (int c = 1; c <= 20; c++) begin
        @(negedge clk);
        if (!busy) busy_low = 1;
        if (reg_tr) rgoff = c;
        if (dne_tr) dnoff = c;
        if (reg_wb_tr) begin roff = c; nwb++; end
        if (mem_wb_tr) begin moff = c; nwb++; end
        if (flag_update_tr) begin foff = c; nwb++; end
        if (fetch_tr) begin lat = c; break; end
      end
      chk($sformatf("v%0d_latency", v), lat, vecs[v].lat);
      chk($sformatf("v%0d_next_pc", v), int'(pc), vecs[v].npc);
      chk($sformatf("v%0d_retired", v), int'(retired), v + 1);
      chk($sformatf("v%0d_reg_tr_off", v), rgoff, 1);
      chk($sformatf("v%0d_dne_tr_off", v), dnoff, 2);
      chk($sformatf("v%0d_reg_wb_off", v), roff, vecs[v].roff);
      chk($sformatf("v%0d_mem_wb_off", v), moff, vecs[v].moff);
      chk($sformatf("v%0d_flag_off", v), foff, vecs[v].foff);
      chk($sformatf("v%0d_wb_pulses", v), nwb, int'(vecs[v].rw) + int'(vecs[v].mw) + int'(vecs[v].fu));
      chk($sformatf("v%0d_busy_low", v), busy_low, 0);
    end

    // Reset pulled in the middle of the memory write-back.
    set_in(1, 1, 0, 0, 0, 16'd0, 16'd0);
    moff = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_wb_tr) begin moff = 1; break; end
    end
    chk("midrst_reached_wb_mem", moff, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_triggers", int'({fetch_tr, reg_tr, dne_tr, reg_wb_tr, mem_wb_tr, flag_update_tr}), 0);
    chk("midrst_pc", int'(pc), 0);
    chk("midrst_retired", int'(retired), 0);
    chk("midrst_busy", int'(busy), 0);
    set_in(0, 0, 0, 0, 0, 16'd0, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    lat = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (fetch_tr | reg_tr | dne_tr | reg_wb_tr | mem_wb_tr | flag_update_tr) begin
        chk("midrst_first_pulse", int'({fetch_tr, reg_tr, dne_tr, reg_wb_tr, mem_wb_tr, flag_update_tr}), 32);
        lat = c;
        break;
      end
    end
    chk("midrst_first_pulse_cycle", lat, 1);
    chk("midrst_fetch_pc", int'(pc), 0);

    // halt_req raised during EXEC: instruction retires, then the FSM parks in IDLE.
    dnoff = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (dne_tr) begin dnoff = 1; break; end
    end
    chk("halt_reached_exec", dnoff, 1);
    halt_req = 1'b1;
    nfetch = 0; idle_seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (fetch_tr) nfetch++;
      if (!busy) begin idle_seen = 1; break; end
    end
    chk("halt_idle_reached", idle_seen, 1);
    chk("halt_retired", int'(retired), 1);
    chk("halt_pc", int'(pc), 2);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (fetch_tr) nfetch++;
      if (busy) idle_seen = 0;
    end
    chk("halt_no_fetch", nfetch, 0);
    chk("halt_stays_idle", idle_seen, 1);

    halt_req = 1'b0;
    wait_fetch("resume");
    chk("resume_pc", int'(pc), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
- Central stage controller for the 16-bit CPU core.
- Owns the PC and sequences each instruction through fetch, register read/decode, execute and write-back by issuing one-cycle trigger pulses to mem, registers and execute.
- Issues write-backs strictly one per cycle in a fixed order, with the PC update last, so no write-back counting or stall logic is needed elsewhere.

Parameters:
WORD, 16, datapath/PC width in bits
PC_STEP, 2, byte increment per instruction; jump targets are scaled by this value

Ports:
clk  input  1  core clock, all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
run  input  1  start/continue execution
halt_req  input  1  stop after the current instruction retires
reg_wb_en  input  1  execute result: register write-back required
mem_wb_en  input  1  execute result: memory write-back required
flag_update_en  input  1  execute result: SREG update required
jump  input  1  absolute jump taken
rjump  input  1  relative jump taken
jump_loc  input  WORD  absolute target, in instruction units
jump_inc  input  WORD  signed relative offset, in instruction units
fetch_tr  output  1  memory instruction fetch pulse
reg_tr  output  1  register read pulse
dne_tr  output  1  decode/execute pulse
reg_wb_tr  output  1  register write-back pulse
mem_wb_tr  output  1  memory write-back pulse
flag_update_tr  output  1  SREG write pulse
pc  output  WORD  current fetch address
busy  output  1  high in every state except IDLE
retired  output  WORD  count of retired instructions

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - pc=0, retired=0, all trigger outputs 0, busy=0, pending mask cleared.
  - Takes effect immediately, mid-instruction included. No partial write-back pulse may follow reset release.
- All outputs are registered. Each trigger is high for exactly one cycle: the cycle the FSM occupies the matching state.
- FSM states and transitions:
  - IDLE: all triggers 0. run=1 -> FETCH.
  - FETCH: fetch_tr=1 -> DECODE.
  - DECODE: reg_tr=1; pc <= pc + PC_STEP -> EXEC.
  - EXEC: dne_tr=1 -> SAMPLE.
  - SAMPLE: latch pending mask {reg_wb_en, mem_wb_en, flag_update_en, jump|rjump}, plus jump, rjump, jump_loc and jump_inc. Inputs are ignored outside SAMPLE. Next state is WB_REG / WB_MEM / WB_FLAG / PC_UPD for the first set bit in that order, else DONE.
  - WB_REG, WB_MEM, WB_FLAG: pulse the matching trigger, clear its pending bit, go to the next pending state in order (PC_UPD is last), else DONE.
  - PC_UPD: pc updated as below -> DONE.
  - DONE: retired <= retired+1 (wraps at 2^WORD). run=1 and halt_req=0 -> FETCH; otherwise -> IDLE.
- PC arithmetic, all modulo 2^WORD:
  - Absolute jump: pc <= jump_loc*PC_STEP.
  - Relative jump: pc <= pc + jump_inc*PC_STEP - PC_STEP. jump_inc is sign-extended. The subtraction compensates for the increment already applied in DECODE.
  - If jump and rjump are both latched, jump wins.
- Latency, counted from the FETCH cycle to the next FETCH cycle:
  - No write-backs: 5 cycles.
  - Each pending write-back adds 1 cycle; a taken jump adds 1 cycle.
  - Worst case: 9 cycles.
- Run and halt control:
  - halt_req and run are sampled only in DONE and IDLE. Deasserting either mid-instruction never aborts it.
  - run=1 together with halt_req=1 in IDLE: no fetch; state stays IDLE.
- busy falls in the cycle after DONE when the FSM enters IDLE.

Test Plan:
- Reset then run=1, execute returns no enables -> fetch_tr, reg_tr, dne_tr on consecutive cycles; next fetch_tr 5 cycles after the first; pc=2 at second fetch; retired=1.
- SAMPLE with reg_wb_en=1, mem_wb_en=1, flag_update_en=1, no jump -> reg_wb_tr, mem_wb_tr, flag_update_tr on three consecutive cycles, each one cycle wide; next fetch 8 cycles after the previous.
- pc=4, jump=1, jump_loc=10, reg_wb_en=1 -> reg_wb_tr precedes the PC update; next fetch at pc=20.
- pc=20, rjump=1, jump_inc=-3 (0xFFFD) -> next fetch at pc=14. Also pc=0, jump_inc=-1 -> pc=0xFFFE (wrap).
- jump=1 and rjump=1 with jump_loc=3, jump_inc=5 -> pc=6.
- rst_n pulled low during WB_MEM -> all triggers 0 immediately, pc=0, retired=0, IDLE; after release with run=1, the first pulse is fetch_tr. halt_req raised during EXEC -> instruction completes, retired increments, FSM enters IDLE, busy=0, no further fetch_tr.
